// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts one PC address, performs a single req/gnt/rvalid
// memory read, and buffers the result for decode behind a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned             ADDR_WIDTH  = 32,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req_i,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr_i,
  output logic                   fetch_ack_o,
  input  logic                   kill_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  output logic                   instr_err_o,
  output logic                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
  input  logic                   mem_err_i
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    DRAIN,
    HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic                   stale_q, stale_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  instr_addr_q, instr_addr_d;
  logic                   err_q, err_d;
  logic                   misaligned;

  assign misaligned  = |fetch_addr_i[1:0];
  assign fetch_ack_o = fetch_req_i & ~kill_i &
                       ((state_q == IDLE) | ((state_q == HOLD) & instr_ready_i));

  assign mem_req_o     = (state_q == WAIT_GNT);
  assign mem_addr_o    = mem_req_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign instr_valid_o = (state_q == HOLD);
  assign instr_o       = instr_valid_o ? instr_q : NOP_INSTR;
  assign instr_addr_o  = instr_addr_q;
  assign instr_err_o   = instr_valid_o & err_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    stale_d      = stale_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    err_d        = err_q;

    // Acceptance is shared by IDLE and the HOLD handshake; a misaligned PC skips the bus.
    if (fetch_ack_o) begin
      addr_d = fetch_addr_i;
      if (misaligned) begin
        state_d      = HOLD;
        instr_d      = NOP_INSTR;
        instr_addr_d = fetch_addr_i;
        err_d        = 1'b1;
      end else begin
        state_d = WAIT_GNT;
      end
    end else begin
      unique case (state_q)
        WAIT_GNT: begin
          if (mem_gnt_i) begin
            state_d = (stale_q | kill_i) ? DRAIN : WAIT_RVALID;
          end else if (kill_i) begin
            stale_d = 1'b1;
          end
        end
        WAIT_RVALID: begin
          if (mem_rvalid_i && kill_i) begin
            state_d = IDLE;
          end else if (mem_rvalid_i) begin
            state_d      = HOLD;
            instr_d      = mem_err_i ? NOP_INSTR : mem_rdata_i;
            instr_addr_d = addr_q;
            err_d        = mem_err_i;
          end else if (kill_i) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rvalid_i) begin
            state_d = IDLE;
            stale_d = 1'b0;
          end
        end
        HOLD: begin
          if (kill_i || instr_ready_i) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stale_q      <= 1'b0;
      addr_q       <= '0;
      instr_q      <= NOP_INSTR;
      instr_addr_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stale_q      <= stale_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle-by-cycle stimulus with hand-computed
// expectations for fetch, stalls, kills, misalignment, bus error and reset.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ack_o;
  logic        kill_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;
  logic        instr_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req_i   (fetch_req_i),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_ack_o   (fetch_ack_o),
    .kill_i        (kill_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_addr_o  (instr_addr_o),
    .instr_err_o   (instr_err_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_err_i     (mem_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_hold(input string tag, input logic [31:0] ins,
                            input logic [31:0] addr, input logic err);
    check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
    check({tag, "_instr"}, instr_o, ins);
    check({tag, "_addr"},  instr_addr_o, addr);
    check({tag, "_err"},   {31'b0, instr_err_o}, {31'b0, err});
  endtask

  initial begin
    rst_n = 1'b0; fetch_req_i = 1'b0; fetch_addr_i = '0; kill_i = 1'b0;
    instr_ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0; mem_err_i = 1'b0;
    cyc(); cyc();

    // Reset state
    check("rst_req",   {31'b0, mem_req_o}, 32'd0);
    check("rst_maddr", mem_addr_o, 32'd0);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, NOP);
    check("rst_iaddr", instr_addr_o, 32'd0);
    check("rst_err",   {31'b0, instr_err_o}, 32'd0);
    check("rst_ack",   {31'b0, fetch_ack_o}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic fetch, zero-wait memory
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0074; settle();
    check("b_ack", {31'b0, fetch_ack_o}, 32'd1);
    cyc();
    fetch_req_i = 1'b0; mem_gnt_i = 1'b1; settle();
    check("b_req",   {31'b0, mem_req_o}, 32'd1);
    check("b_maddr", mem_addr_o, 32'h0001_0074);
    check("b_ack0",  {31'b0, fetch_ack_o}, 32'd0);
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0050_0093; settle();
    check("b_req_drop", {31'b0, mem_req_o}, 32'd0);
    check("b_novalid",  {31'b0, instr_valid_o}, 32'd0);
    cyc();
    mem_rvalid_i = 1'b0; instr_ready_i = 1'b1; settle();
    check_hold("b", 32'h0050_0093, 32'h0001_0074, 1'b0);
    cyc();
    instr_ready_i = 1'b0; settle();
    check("b_consumed", {31'b0, instr_valid_o}, 32'd0);

    // Back-to-back with a 2-cycle grant delay and 3 cycles of decode stall
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0074; settle();
    check("bb_ack1", {31'b0, fetch_ack_o}, 32'd1);
    cyc();
    fetch_req_i = 1'b0; settle();
    for (int i = 0; i < 2; i++) begin
      check("bb_req_wait",   {31'b0, mem_req_o}, 32'd1);
      check("bb_maddr_wait", mem_addr_o, 32'h0001_0074);
      cyc();
    end
    mem_gnt_i = 1'b1; settle();
    check("bb_maddr_gnt", mem_addr_o, 32'h0001_0074);
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00a0_0113; settle();
    cyc();
    mem_rvalid_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0078;
    mem_rdata_i = 32'hFFFF_FFFF; settle();
    for (int i = 0; i < 3; i++) begin
      check_hold("bb_stall", 32'h00a0_0113, 32'h0001_0074, 1'b0);
      check("bb_stall_ack", {31'b0, fetch_ack_o}, 32'd0);
      cyc();
    end
    instr_ready_i = 1'b1; settle();
    check_hold("bb_hs", 32'h00a0_0113, 32'h0001_0074, 1'b0);
    check("bb_ack2", {31'b0, fetch_ack_o}, 32'd1);
    cyc();
    instr_ready_i = 1'b0; fetch_req_i = 1'b0; mem_gnt_i = 1'b1; settle();
    check("bb_valid_gap", {31'b0, instr_valid_o}, 32'd0);
    check("bb_maddr2",    mem_addr_o, 32'h0001_0078);
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00b0_0193; settle();
    cyc();
    mem_rvalid_i = 1'b0; instr_ready_i = 1'b1; settle();
    check_hold("bb2", 32'h00b0_0193, 32'h0001_0078, 1'b0);
    cyc();
    instr_ready_i = 1'b0; settle();

    // Kill in WAIT_RVALID, late rvalid drained
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0080; settle();
    cyc();
    fetch_req_i = 1'b0; mem_gnt_i = 1'b1; settle();
    cyc();
    mem_gnt_i = 1'b0; kill_i = 1'b1; settle();
    cyc();
    kill_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0100; settle();
    check("kr_drain_ack",   {31'b0, fetch_ack_o}, 32'd0);
    check("kr_drain_req",   {31'b0, mem_req_o}, 32'd0);
    check("kr_drain_valid", {31'b0, instr_valid_o}, 32'd0);
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; settle();
    check("kr_rv_ack", {31'b0, fetch_ack_o}, 32'd0);
    cyc();
    mem_rvalid_i = 1'b0; settle();
    check("kr_idle_valid", {31'b0, instr_valid_o}, 32'd0);
    check("kr_idle_ack",   {31'b0, fetch_ack_o}, 32'd1);
    cyc();
    fetch_req_i = 1'b0; mem_gnt_i = 1'b1; settle();
    check("kr_maddr", mem_addr_o, 32'h0001_0100);
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00c0_0213; settle();
    cyc();
    mem_rvalid_i = 1'b0; instr_ready_i = 1'b1; settle();
    check_hold("kr_new", 32'h00c0_0213, 32'h0001_0100, 1'b0);
    cyc();
    instr_ready_i = 1'b0; settle();

    // Kill in WAIT_GNT: request held until grant, response dropped
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0200; settle();
    cyc();
    fetch_req_i = 1'b0; kill_i = 1'b1; settle();
    check("kg_req_kill", {31'b0, mem_req_o}, 32'd1);
    cyc();
    kill_i = 1'b0; settle();
    check("kg_req_held", {31'b0, mem_req_o}, 32'd1);
    check("kg_maddr",    mem_addr_o, 32'h0001_0200);
    mem_gnt_i = 1'b1;
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111; settle();
    check("kg_req_off", {31'b0, mem_req_o}, 32'd0);
    cyc();
    mem_rvalid_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0300; settle();
    check("kg_dropped", {31'b0, instr_valid_o}, 32'd0);
    check("kg_idle_ack", {31'b0, fetch_ack_o}, 32'd1);

    // Kill coincident with rvalid
    cyc();
    fetch_req_i = 1'b0; mem_gnt_i = 1'b1; settle();
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; kill_i = 1'b1; mem_rdata_i = 32'h2222_2222; settle();
    cyc();
    mem_rvalid_i = 1'b0; kill_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0076; settle();
    check("kv_dropped",  {31'b0, instr_valid_o}, 32'd0);
    check("kv_idle_ack", {31'b0, fetch_ack_o}, 32'd1);

    // Misaligned fetch: no bus access, error instruction next cycle
    cyc();
    fetch_req_i = 1'b0; instr_ready_i = 1'b1; settle();
    check("mis_req", {31'b0, mem_req_o}, 32'd0);
    check_hold("mis", NOP, 32'h0001_0076, 1'b1);
    cyc();
    instr_ready_i = 1'b0; settle();
    check("mis_req_after", {31'b0, mem_req_o}, 32'd0);

    // Bus error, then kill overrides ready in HOLD
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0400; settle();
    cyc();
    fetch_req_i = 1'b0; mem_gnt_i = 1'b1; settle();
    cyc();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; settle();
    cyc();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; settle();
    check_hold("berr", NOP, 32'h0001_0400, 1'b1);
    kill_i = 1'b1; instr_ready_i = 1'b1; fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0500; settle();
    check("kh_ack", {31'b0, fetch_ack_o}, 32'd0);
    cyc();
    kill_i = 1'b0; instr_ready_i = 1'b0; fetch_req_i = 1'b0; settle();
    check("kh_valid", {31'b0, instr_valid_o}, 32'd0);
    check("kh_req",   {31'b0, mem_req_o}, 32'd0);

    // Reset during WAIT_RVALID, then a stray rvalid
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0500; settle();
    cyc();
    fetch_req_i = 1'b0; mem_gnt_i = 1'b1; settle();
    cyc();
    mem_gnt_i = 1'b0; rst_n = 1'b0; settle();
    cyc();
    check("rr_req",   {31'b0, mem_req_o}, 32'd0);
    check("rr_maddr", mem_addr_o, 32'd0);
    check("rr_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rr_instr", instr_o, NOP);
    check("rr_iaddr", instr_addr_o, 32'd0);
    check("rr_err",   {31'b0, instr_err_o}, 32'd0);
    rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3333_3333;
    cyc();
    mem_rvalid_i = 1'b0; settle();
    check("rr_stray_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rr_stray_req",   {31'b0, mem_req_o}, 32'd0);
    check("rr_stray_iaddr", instr_addr_o, 32'd0);
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0001_0600; settle();
    check("rr_idle_ack", {31'b0, fetch_ack_o}, 32'd1);
    fetch_req_i = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
